// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order writeback stage, which always wins,
// and a long-latency unit whose results wait in a small FIFO with WAW squash and starvation stall.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              ll_valid,
  input  logic [ADDR_W-1:0] ll_rd,
  input  logic [DATA_W-1:0] ll_data,
  output logic              ll_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wd,
  output logic              stall_req,
  output logic              ll_pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, live_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        wait_q, wait_d;
  logic              stall_q, stall_d;

  logic pipe_wr, head_valid, head_live, grant_ll, pop, push, head_squash;

  assign pipe_wr     = RegWriteW && (RdW != '0);
  assign head_valid  = valid_q[head_q];
  assign head_live   = head_valid && live_q[head_q];
  assign grant_ll    = !pipe_wr && head_live;
  // A dead head leaves the buffer even while the pipeline owns the port.
  assign pop         = head_valid && (grant_ll || !live_q[head_q]);
  assign ll_ready    = (count_q < CNT_W'(DEPTH));
  assign push        = ll_valid && ll_ready && (ll_rd != '0);
  assign head_squash = pipe_wr && head_live && (rd_q[head_q] == RdW);

  assign ll_pending  = |(valid_q & live_q);
  assign stall_req   = stall_q;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_wd   = '0;
    wait_d  = '0;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pipe_wr) begin
      rf_we = 1'b1;
      rf_rd = RdW;
      rf_wd = ResultW;
    end else if (head_live) begin
      rf_we = 1'b1;
      rf_rd = rd_q[head_q];
      rf_wd = data_q[head_q];
    end
    if (head_live && pipe_wr && !head_squash)
      wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    // Saturating counter keeps stall asserted if the pipeline ignores it.
    stall_d = (wait_d >= 4'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q <= '0;
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pipe_wr && valid_q[i] && (rd_q[i] == RdW))
          live_q[i] <= 1'b0;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        live_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // Written after the squash loop so a same-cycle enqueue stays live.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        live_q[tail_q]  <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // NOTE: the payload storage is deliberately not reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= ll_rd;
      data_q[tail_q] <= ll_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed port and flag values per cycle.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [15:0] ResultW;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [15:0] ll_data;
  logic        ll_ready, rf_we, stall_req, ll_pending;
  logic [4:0]  rf_rd;
  logic [15:0] rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data),
    .ll_ready(ll_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .stall_req(stall_req), .ll_pending(ll_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs just after an edge and let combinational outputs settle.
  task automatic drive(input logic pw, input logic [4:0] prd, input logic [15:0] pres,
                       input logic lv, input logic [4:0] lrd, input logic [15:0] ldat);
    RegWriteW = pw;  RdW = prd;  ResultW = pres;
    ll_valid  = lv;  ll_rd = lrd; ll_data = ldat;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_port(input string tag, input logic we, input logic [4:0] rd, input logic [15:0] wd);
    check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    if (we) begin
      check({tag, ".rf_rd"}, 32'(rf_rd), 32'(rd));
      check({tag, ".rf_wd"}, 32'(rf_wd), 32'(wd));
    end
  endtask

  task automatic expect_flags(input string tag, input logic rdy, input logic pend, input logic stl);
    check({tag, ".ll_ready"},   32'(ll_ready),   32'(rdy));
    check({tag, ".ll_pending"}, 32'(ll_pending), 32'(pend));
    check({tag, ".stall_req"},  32'(stall_req),  32'(stl));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    expect_port("reset", 0, 0, 0);
    expect_flags("reset", 1, 0, 0);
    tick();

    // Pipeline-only writes, then RdW=0 counts as idle.
    drive(1, 3, 16'h00AA, 0, 0, 0);
    expect_port("pipe_w3", 1, 3, 16'h00AA);
    tick();
    drive(1, 0, 16'h5555, 0, 0, 0);
    expect_port("pipe_r0", 0, 0, 0);
    tick();

    // Single LL result: no bypass, written one cycle after acceptance.
    drive(0, 0, 0, 1, 5, 16'h1234);
    expect_port("ll5_acc", 0, 0, 0);
    check("ll5_acc.pending", 32'(ll_pending), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("ll5_wr", 1, 5, 16'h1234);
    check("ll5_wr.pending", 32'(ll_pending), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("ll5_done", 0, 0, 0);
    check("ll5_done.pending", 32'(ll_pending), 32'd0);
    tick();

    // Fill with rd=6, rd=7 while pipeline writes r1 every cycle.
    drive(1, 1, 16'h1111, 1, 6, 16'h6666);
    expect_port("fill_a", 1, 1, 16'h1111);
    expect_flags("fill_a", 1, 0, 0);
    tick();
    drive(1, 1, 16'h1111, 1, 7, 16'h7777);
    expect_port("fill_b", 1, 1, 16'h1111);
    expect_flags("fill_b", 1, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'h1111, 1, 8, 16'h8888);
      expect_flags($sformatf("starve%0d", i), 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    expect_port("drain6", 1, 6, 16'h6666);
    expect_flags("drain6", 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("drain7", 1, 7, 16'h7777);
    expect_flags("drain7", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("drained", 0, 0, 0);
    expect_flags("drained", 1, 0, 0);
    tick();

    // WAW squash of a buffered r9 by a pipeline write to r9.
    drive(0, 0, 0, 1, 9, 16'h0001);
    tick();
    drive(1, 9, 16'hBEEF, 0, 0, 0);
    expect_port("waw_pipe", 1, 9, 16'hBEEF);
    check("waw_pipe.pending", 32'(ll_pending), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("waw_dead", 0, 0, 0);
    check("waw_dead.pending", 32'(ll_pending), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("waw_after", 0, 0, 0);
    check("waw_after.ready", 32'(ll_ready), 32'd1);
    tick();

    // Same-cycle enqueue to the register being written is not squashed.
    drive(1, 12, 16'hAAAA, 1, 12, 16'hC0DE);
    expect_port("same_pipe", 1, 12, 16'hAAAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("same_ll", 1, 12, 16'hC0DE);
    tick();

    // ll_rd=0 is dropped.
    drive(0, 0, 0, 1, 0, 16'hFFFF);
    check("rd0_acc.ready", 32'(ll_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("rd0_after", 0, 0, 0);
    check("rd0_after.pending", 32'(ll_pending), 32'd0);
    tick();

    // Reset with two entries buffered.
    drive(1, 2, 16'h2222, 1, 10, 16'h000A);
    tick();
    drive(1, 2, 16'h2222, 1, 11, 16'h000B);
    tick();
    drive(1, 2, 16'h2222, 0, 0, 0);
    expect_flags("full", 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    expect_port("post_rst", 0, 0, 0);
    expect_flags("post_rst", 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_port("post_rst2", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage (fixed priority, never stalled by this block) and a long-latency unit (LL, e.g. iterative mul/div) through a small buffer.
- Sits after the writeback-stage result mux and drives the register file write port.
- Squashes stale LL results on WAW conflicts and requests a pipeline bubble when a buffered LL result is starved.

Parameters:
DATA_W, 16, data width of results and register write data
ADDR_W, 5, register address width
DEPTH, 2, LL buffer entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive ungranted cycles before stall_req asserts (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
RegWriteW  in  1  pipeline writeback request
RdW  in  ADDR_W  pipeline destination register
ResultW  in  DATA_W  pipeline result
ll_valid  in  1  LL result valid
ll_rd  in  ADDR_W  LL destination register
ll_data  in  DATA_W  LL result
ll_ready  out  1  buffer can accept; equals (count < DEPTH)
rf_we  out  1  register file write enable
rf_rd  out  ADDR_W  register file write address
rf_wd  out  DATA_W  register file write data
stall_req  out  1  registered; upstream must present RegWriteW=0 next cycle
ll_pending  out  1  buffer holds at least one live entry

Behaviour:
- Reset, synchronous: buffer empty, all entry valid bits 0, wait counter 0, stall_req=0; hence ll_ready=1, ll_pending=0, rf_we=0.
- Enqueue on ll_valid && ll_ready at the rising edge. Entries with ll_rd==0 are dropped: not stored, no write.
- No bypass: an LL result writes the port at least 1 cycle after acceptance.
- ll_ready depends on registered count only. A dequeue in the same cycle does not free a slot for that cycle's enqueue when full. Enqueue plus dequeue in the same cycle when not full is allowed; count unchanged.
- Port selection, combinational, same cycle:
  - If RegWriteW && RdW!=0: rf_we=1, rf_rd=RdW, rf_wd=ResultW.
  - Else, if the head entry is live: rf_we=1, rf_rd/rf_wd from head; head popped at the edge.
  - Else rf_we=0.
  - RegWriteW with RdW==0 counts as idle.
- Dead heads: a squashed head entry is popped without a write in any cycle, including cycles where the pipeline owns the port. It costs one cycle per entry.
- WAW squash: when the pipeline writes RdW!=0, every buffered entry with rd==RdW is marked dead at that edge. An LL result enqueued in the same cycle is not squashed.
- Ordering: buffer strictly FIFO; the wrap-around pointer is modulo DEPTH.
- Starvation:
  - The wait counter increments each cycle a live head exists and is not granted.
  - It clears on grant, on the head dying, or when the buffer is empty.
  - When the counter reaches STARVE_LIMIT, stall_req is set at that edge.
  - stall_req clears at the edge where the live head is granted.
  - If RegWriteW=1 while stall_req=1 (protocol violation), the pipeline still wins and stall_req holds.
- ll_pending = OR of valid&live over entries, combinational from registers.
- Reset asserted mid-operation discards all buffered entries; rf_we is 0 the cycle after.

Test Plan:
- Reset, then idle -> rf_we=0, ll_ready=1, stall_req=0, ll_pending=0.
- Pipeline-only writes: RegWriteW=1, RdW=3, ResultW=16'h00AA, then RdW=0 -> first cycle rf_we=1, rf_rd=3, rf_wd=00AA; second cycle rf_we=0.
- LL rd=5, data=16'h1234 accepted in cycle 0, pipeline idle -> cycle 1 rf_we=1, rf_rd=5, rf_wd=1234; ll_pending 1 then 0.
- Fill buffer with rd=6 and rd=7 while the pipeline writes every cycle:
  - ll_ready=0 after 2 accepts.
  - stall_req=1 after 4 ungranted cycles.
  - Pipeline then idles: rd=6 written, then rd=7; stall_req=0 after the rd=6 grant.
- WAW: buffer holds rd=9 (data 16'h0001); pipeline writes RdW=9 data 16'hBEEF -> rf shows only the 9<-BEEF write. Next idle cycle: dead entry popped with rf_we=0, ll_pending=0.
- ll_rd=0 with ll_valid=1 -> never stored, ll_pending stays 0, no write.
- rst asserted with 2 entries buffered -> next cycle count 0, ll_ready=1, rf_we=0.
